// File: rtl/riscv_core_mem_arb_pkg.sv
// riscv_core_mem_arb_pkg: shared state and owner encodings for the memory read arbiter
package riscv_core_mem_arb_pkg;
  typedef enum logic {IDLE, BUSY} state_t;
  typedef enum logic {OWN_IC = 1'b0, OWN_DC = 1'b1} owner_t;
endpackage

// File: rtl/riscv_core_rr_arbiter2.sv
// riscv_core_rr_arbiter2: two-way grant logic; round-robin pointer when RISCV_MEM_ARB_RR_EN is defined, else D-cache wins ties
module riscv_core_rr_arbiter2
  import riscv_core_mem_arb_pkg::*;
(
`ifdef RISCV_MEM_ARB_RR_EN
  input  logic   i_clk,
  input  logic   i_rst,
  input  logic   grant_en,
`endif
  input  logic   ic_req,
  input  logic   dc_req,
  output owner_t winner
);
`ifdef RISCV_MEM_ARB_RR_EN
  owner_t last_q;
  always_ff @(posedge i_clk)
    if (i_rst) last_q <= OWN_IC;
    else if (grant_en) last_q <= winner;
  // pointer resets to I-cache so the D-cache takes the first tie
  assign winner = (dc_req && (!ic_req || last_q == OWN_IC)) ? OWN_DC : OWN_IC;
`else
  assign winner = dc_req ? OWN_DC : OWN_IC;
`endif
endmodule

// File: rtl/riscv_core_mem_read_arbiter.sv
// riscv_core_mem_read_arbiter: shares the AXI read channel between I-cache and D-cache refills
// RISCV_MEM_ARB_RR_EN selects round-robin tie-breaking instead of fixed D-cache priority
module riscv_core_mem_read_arbiter
  import riscv_core_mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_ic_read_req,
  input  logic [ADDR_WIDTH-1:0] i_ic_read_address,
  output logic                  o_ic_read_done,
  input  logic                  i_dc_read_req,
  input  logic [ADDR_WIDTH-1:0] i_dc_read_address,
  output logic                  o_dc_read_done,
  output logic                  o_mem_read_req,
  output logic [ADDR_WIDTH-1:0] o_mem_read_address,
  input  logic                  i_mem_read_done,
  output logic                  o_busy,
  output logic                  o_owner
);
  state_t state;
  owner_t owner_q;
  owner_t winner;
  logic   grant;
  logic   done;
  assign grant = state == IDLE && (i_ic_read_req || i_dc_read_req);
  riscv_core_rr_arbiter2 u_arb (
`ifdef RISCV_MEM_ARB_RR_EN
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .grant_en (grant),
`endif
    .ic_req   (i_ic_read_req),
    .dc_req   (i_dc_read_req),
    .winner   (winner)
  );
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state              <= IDLE;
      owner_q            <= OWN_IC;
      o_mem_read_req     <= 1'b0;
      o_mem_read_address <= '0;
    end else if (state == IDLE) begin
      if (grant) begin
        state              <= BUSY;
        owner_q            <= winner;
        o_mem_read_req     <= 1'b1;
        o_mem_read_address <= winner == OWN_DC ? i_dc_read_address : i_ic_read_address;
      end
    end else if (i_mem_read_done) begin
      state          <= IDLE;
      o_mem_read_req <= 1'b0;
    end
  end
  // completion is routed combinationally to the latched owner, never the live requester
  assign done           = state == BUSY && i_mem_read_done && !i_rst;
  assign o_ic_read_done = done && owner_q == OWN_IC;
  assign o_dc_read_done = done && owner_q == OWN_DC;
  assign o_busy         = state == BUSY;
  assign o_owner        = owner_q;
endmodule
